// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the sequential ALU: 4-bit opcode constants, the
// handshake state encoding and opcode classification helpers.
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SLTU  = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_MUL   = 4'b1000;
  localparam logic [3:0] OP_MULHU = 4'b1001;
  localparam logic [3:0] OP_DIVU  = 4'b1010;
  localparam logic [3:0] OP_REMU  = 4'b1011;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam logic [3:0] OP_EQ    = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Ops served by the iterative multiply/divide datapath.
  function automatic logic is_multicycle(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_MULHU) ||
           (op == OP_DIVU) || (op == OP_REMU);
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/seq_alu_muldiv.sv
// -----------------------------------------------------------------------------
// seq_alu_muldiv
// Iterative unsigned multiply (shift-add) and restoring divide, one step per
// clock. The first step is taken on the start edge, so the remaining
// WIDTH-1 steps finish and done pulses in the WIDTH-th cycle after start.
//
// Ports
//   clk, rst_n      clock, async active-low reset
//   start           load operands and begin (one-cycle pulse)
//   op              opcode, only multiply vs divide matters here
//   a, b            operands (multiplicand/multiplier or dividend/divisor)
//   done            one-cycle pulse: acc holds the final value
//   acc             multiply: {hi, lo} product; divide: {remainder, quotient}
// -----------------------------------------------------------------------------
module seq_alu_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [3:0]           op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   acc
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic                 busy;
  logic [CNT_W-1:0]     step_cnt;
  logic                 div_q;
  logic [WIDTH-1:0]     opd_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic                 done_q;

  logic                 div_sel;
  logic [WIDTH-1:0]     opd_sel;
  logic [2*WIDTH-1:0]   acc_src;
  logic [2*WIDTH-1:0]   acc_nxt;

  // acc = {partial_hi, multiplier}; multiplier bits are consumed from bit 0
  // while the product shifts in from the top.
  function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] cur,
                                                  input logic [WIDTH-1:0]   mcand);
    logic [WIDTH:0] sum;
    sum = cur[0] ? ({1'b0, cur[2*WIDTH-1:WIDTH]} + {1'b0, mcand})
                 : {1'b0, cur[2*WIDTH-1:WIDTH]};
    return {sum, cur[WIDTH-1:1]};
  endfunction

  // acc = {remainder, dividend/quotient}; bit WIDTH of the trial difference
  // is the borrow, i.e. clear when the shifted remainder covers the divisor.
  function automatic logic [2*WIDTH-1:0] div_step(input logic [2*WIDTH-1:0] cur,
                                                  input logic [WIDTH-1:0]   dvsr);
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;
    rem_sh = {cur[2*WIDTH-1:WIDTH], cur[WIDTH-1]};
    diff   = rem_sh - {1'b0, dvsr};
    if (!diff[WIDTH])
      return {diff[WIDTH-1:0], cur[WIDTH-2:0], 1'b1};
    else
      return {rem_sh[WIDTH-1:0], cur[WIDTH-2:0], 1'b0};
  endfunction

  always_comb begin
    div_sel = div_q;
    opd_sel = opd_q;
    acc_src = acc_q;
    if (start) begin
      div_sel = is_div(op);
      opd_sel = is_div(op) ? b : a;
      acc_src = {{WIDTH{1'b0}}, (is_div(op) ? a : b)};
    end
    acc_nxt = div_sel ? div_step(acc_src, opd_sel) : mul_step(acc_src, opd_sel);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      step_cnt <= '0;
      div_q    <= 1'b0;
      opd_q    <= '0;
      acc_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        busy     <= 1'b1;
        step_cnt <= CNT_W'(WIDTH - 1);
        div_q    <= div_sel;
        opd_q    <= opd_sel;
        acc_q    <= acc_nxt;
      end else if (busy) begin
        acc_q    <= acc_nxt;
        step_cnt <= step_cnt - 1'b1;
        if (step_cnt == CNT_W'(1)) begin
          busy   <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done = done_q;
  assign acc  = acc_q;

endmodule

// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu
// Sequential ALU with valid/ready handshakes on both sides. Logic, compare
// and add/sub ops complete in one cycle; multiply and divide iterate in
// seq_alu_muldiv. Results and flags are registered and held in DONE until
// the consumer takes them.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   in_valid / in_ready        request handshake (A_in, B_in, ALU_Sel)
//   out_valid / out_ready      result handshake
//   ALU_Out                    result
//   Carry_Out, Zero, Overflow, Div_Zero   status flags
//
// state | meaning
// IDLE  | ready for a request
// BUSY  | multiply/divide iterating
// DONE  | result valid, waiting for out_ready
// -----------------------------------------------------------------------------
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int REG_OUT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  A_in,
  input  logic [WIDTH-1:0]  B_in,
  input  logic [3:0]        ALU_Sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  ALU_Out,
  output logic              Carry_Out,
  output logic              Zero,
  output logic              Overflow,
  output logic              Div_Zero
);

  generate
    if (REG_OUT != 1) begin : g_bad_reg_out
      $error("seq_alu: only REG_OUT = 1 is supported");
    end
    if (WIDTH < 8 || WIDTH > 64) begin : g_bad_width
      $error("seq_alu: WIDTH must be between 8 and 64");
    end
  endgenerate

  state_t               state;
  logic                 sel_hi_q;
  logic                 accept;
  logic                 start_md;
  logic                 md_done;
  logic [2*WIDTH-1:0]   md_acc;
  logic [WIDTH-1:0]     md_res;

  logic [WIDTH:0]       sum;
  logic [WIDTH:0]       diff;
  logic [WIDTH-1:0]     sc_res;
  logic                 sc_carry;
  logic                 sc_ovf;
  logic                 sc_dz;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;
  // A zero multiplier or divisor has a known answer, so skip the iteration.
  assign start_md = accept && is_multicycle(ALU_Sel) && (B_in != '0);

  always_comb begin
    sum      = {1'b0, A_in} + {1'b0, B_in};
    diff     = {1'b0, A_in} - {1'b0, B_in};
    sc_res   = sum[WIDTH-1:0];
    sc_carry = 1'b0;
    sc_ovf   = 1'b0;
    sc_dz    = 1'b0;
    case (ALU_Sel)
      OP_AND:   sc_res = A_in & B_in;
      OP_OR:    sc_res = A_in | B_in;
      OP_NOR:   sc_res = ~(A_in | B_in);
      OP_SLT:   sc_res = WIDTH'($signed(A_in) < $signed(B_in));
      OP_SLTU:  sc_res = WIDTH'(A_in < B_in);
      OP_EQ:    sc_res = WIDTH'(A_in == B_in);
      OP_SUB: begin
        sc_res   = diff[WIDTH-1:0];
        sc_carry = ~diff[WIDTH];
        sc_ovf   = (A_in[WIDTH-1] != B_in[WIDTH-1]) &&
                   (diff[WIDTH-1] != A_in[WIDTH-1]);
      end
      OP_MUL, OP_MULHU: sc_res = '0;
      OP_DIVU: begin
        sc_res = '1;
        sc_dz  = 1'b1;
      end
      OP_REMU: begin
        sc_res = A_in;
        sc_dz  = 1'b1;
      end
      default: begin
        sc_res   = sum[WIDTH-1:0];
        sc_carry = sum[WIDTH];
        sc_ovf   = (A_in[WIDTH-1] == B_in[WIDTH-1]) &&
                   (sum[WIDTH-1] != A_in[WIDTH-1]);
      end
    endcase
  end

  seq_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start_md),
    .op    (ALU_Sel),
    .a     (A_in),
    .b     (B_in),
    .done  (md_done),
    .acc   (md_acc)
  );

  // Opcode bit 0 picks the upper accumulator half: MULHU high product, REMU
  // remainder; MUL and DIVU take the lower half.
  assign md_res = sel_hi_q ? md_acc[2*WIDTH-1:WIDTH] : md_acc[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sel_hi_q  <= 1'b0;
      out_valid <= 1'b0;
      ALU_Out   <= '0;
      Carry_Out <= 1'b0;
      Zero      <= 1'b0;
      Overflow  <= 1'b0;
      Div_Zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sel_hi_q <= ALU_Sel[0];
            if (start_md) begin
              state <= BUSY;
            end else begin
              state     <= DONE;
              out_valid <= 1'b1;
              ALU_Out   <= sc_res;
              Carry_Out <= sc_carry;
              Zero      <= (sc_res == '0);
              Overflow  <= sc_ovf;
              Div_Zero  <= sc_dz;
            end
          end
        end
        BUSY: begin
          if (md_done) begin
            state     <= DONE;
            out_valid <= 1'b1;
            ALU_Out   <= md_res;
            Carry_Out <= 1'b0;
            Zero      <= (md_res == '0);
            Overflow  <= 1'b0;
            Div_Zero  <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] A_in = '0;
  logic [31:0] B_in = '0;
  logic [3:0]  ALU_Sel = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] ALU_Out;
  logic        Carry_Out, Zero, Overflow, Div_Zero;

  int checks = 0;
  int failures = 0;

  logic [31:0] got_res;
  logic [3:0]  got_flags;   // {Carry_Out, Zero, Overflow, Div_Zero}
  int          got_lat;

  seq_alu #(.WIDTH(32), .REG_OUT(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A_in      (A_in),
    .B_in      (B_in),
    .ALU_Sel   (ALU_Sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ALU_Out   (ALU_Out),
    .Carry_Out (Carry_Out),
    .Zero      (Zero),
    .Overflow  (Overflow),
    .Div_Zero  (Div_Zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on 64-bit values.
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic [3:0] flags, output int lat);
    longint unsigned ua, ub, p, s;
    longint sa, sb, sd;
    logic c, o, dz;
    ua = 64'(a); ub = 64'(b);
    sa = longint'($signed(a)); sb = longint'($signed(b));
    c = 0; o = 0; dz = 0; lat = 1;
    p = ua * ub;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b1100: r = ~(a | b);
      4'b0111: r = (sa < sb) ? 32'd1 : 32'd0;
      4'b0011: r = (ua < ub) ? 32'd1 : 32'd0;
      4'b1111: r = (a == b) ? 32'd1 : 32'd0;
      4'b0110: begin
        r  = a - b;
        c  = (ua >= ub);
        sd = sa - sb;
        o  = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
      end
      4'b1000: begin r = p[31:0];  lat = (b != 0) ? 33 : 1; end
      4'b1001: begin r = p[63:32]; lat = (b != 0) ? 33 : 1; end
      4'b1010: begin
        if (b == 0) begin r = 32'hFFFFFFFF; dz = 1; end
        else begin r = 32'(ua / ub); lat = 33; end
      end
      4'b1011: begin
        if (b == 0) begin r = a; dz = 1; end
        else begin r = 32'(ua % ub); lat = 33; end
      end
      default: begin
        s  = ua + ub;
        r  = s[31:0];
        c  = (s > 64'hFFFFFFFF);
        sd = sa + sb;
        o  = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
      end
    endcase
    flags = {c, (r == 0), o, dz};
  endtask

  // Called at a point away from the clock edge with the DUT in IDLE.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int hold);
    logic [31:0] er;
    logic [3:0]  ef;
    int          elat, lat;
    logic        rdy_bad;
    model(op, a, b, er, ef, elat);
    chk("ready_idle", 64'(in_ready), 64'd1);
    A_in = a; B_in = b; ALU_Sel = op; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    A_in = $urandom; B_in = $urandom; ALU_Sel = 4'($urandom_range(0, 15));
    lat = 1; rdy_bad = 1'b0;
    while (!out_valid && lat < 100) begin
      if (in_ready) rdy_bad = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    got_lat = lat;
    chk($sformatf("latency op=%0h", op), 64'(lat), 64'(elat));
    chk("ready_busy", 64'(rdy_bad), 64'd0);
    if (!out_valid) return;
    got_res   = ALU_Out;
    got_flags = {Carry_Out, Zero, Overflow, Div_Zero};
    chk($sformatf("result op=%0h a=%0h b=%0h", op, a, b), 64'(ALU_Out), 64'(er));
    chk($sformatf("flags op=%0h a=%0h b=%0h", op, a, b), 64'(got_flags), 64'(ef));
    chk("ready_done", 64'(in_ready), 64'd0);
    repeat (hold) begin
      @(posedge clk); #1;
      chk("hold", {26'd0, out_valid, in_ready, ALU_Out, Carry_Out, Zero, Overflow, Div_Zero},
          {26'd0, 1'b1, 1'b0, er, ef});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("release", 64'({out_valid, in_ready}), 64'b01);
  endtask

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'h7FFFFFFF;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ghost;
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_outputs", 64'({ALU_Out, Carry_Out, Zero, Overflow, Div_Zero}), 64'd0);
    @(negedge clk); rst_n = 1'b1;

    // First edge after release must accept.
    do_op(4'b0010, 32'h7FFFFFFF, 32'h00000001, 0);
    chk("add_ovf_res", 64'(got_res), 64'h80000000);
    chk("add_ovf_flags", 64'(got_flags), 64'b0010);
    chk("add_ovf_lat", 64'(got_lat), 64'd1);

    do_op(4'b0110, 32'd5, 32'd5, 0);
    chk("sub_eq_res", 64'(got_res), 64'd0);
    chk("sub_eq_flags", 64'(got_flags), 64'b1100);
    do_op(4'b0110, 32'd0, 32'd1, 0);
    chk("sub_borrow_res", 64'(got_res), 64'hFFFFFFFF);
    chk("sub_borrow_flags", 64'(got_flags), 64'b0000);

    do_op(4'b1000, 32'hFFFFFFFF, 32'd2, 0);
    chk("mul_res", 64'(got_res), 64'hFFFFFFFE);
    chk("mul_lat", 64'(got_lat), 64'd33);
    do_op(4'b1001, 32'hFFFFFFFF, 32'd2, 0);
    chk("mulhu_res", 64'(got_res), 64'd1);

    do_op(4'b1010, 32'd100, 32'd7, 0);
    chk("divu_res", 64'(got_res), 64'd14);
    chk("divu_lat", 64'(got_lat), 64'd33);
    do_op(4'b1011, 32'd100, 32'd7, 0);
    chk("remu_res", 64'(got_res), 64'd2);
    do_op(4'b1010, 32'h1234, 32'd0, 0);
    chk("divz_res", 64'(got_res), 64'hFFFFFFFF);
    chk("divz_flag", 64'(got_flags[0]), 64'd1);
    chk("divz_lat", 64'(got_lat), 64'd1);

    do_op(4'b0010, 32'd10, 32'd20, 5);

    // Reset in the middle of a multiply.
    A_in = 32'h12345; B_in = 32'h6789; ALU_Sel = 4'b1000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    chk("pre_rst_busy", 64'({out_valid, in_ready}), 64'b00);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_outputs", 64'({ALU_Out, Carry_Out, Zero, Overflow, Div_Zero}), 64'd0);
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    ghost = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) ghost++;
    end
    chk("no_ghost_result", 64'(ghost), 64'd0);
    do_op(4'b0010, 32'd3, 32'd4, 0);
    chk("post_rst_add", 64'(got_res), 64'd7);

    repeat (150) begin
      do_op(4'($urandom_range(0, 15)), rand_opnd(), rand_opnd(), $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits; SHALL be supported from 8 to 64.
REQ-002 Parameter REG_OUT, default 1: 1 = result, flags and out_valid registered; 0 is not supported and SHALL raise an elaboration error.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 A_in  input  WIDTH  operand A.
REQ-008 B_in  input  WIDTH  operand B.
REQ-009 ALU_Sel  input  4  operation select.
REQ-010 out_valid  output  1  result and flags valid.
REQ-011 out_ready  input  1  consumer takes the result this cycle.
REQ-012 ALU_Out  output  WIDTH  result.
REQ-013 Carry_Out, Zero, Overflow, Div_Zero  output  1 each  status flags.

Function
REQ-014 A transfer occurs when in_valid && in_ready; operands and ALU_Sel SHALL be captured on that edge; later input changes have no effect.
REQ-015 Opcode map:
- 0000 AND; 0001 OR; 0010 ADD; 0110 SUB
- 0111 SLT (signed); 0011 SLTU; 1100 NOR; 1111 EQ (1 if equal)
- 1000 MUL (low WIDTH bits); 1001 MULHU (high WIDTH bits, unsigned)
- 1010 DIVU; 1011 REMU; all others: ADD
REQ-016 State machine: IDLE, BUSY, DONE; in_ready = (state == IDLE).
REQ-017 Single-cycle ops and divide-by-zero SHALL take IDLE -> DONE, so out_valid rises 1 cycle after the accept edge.
REQ-018 MUL, MULHU, DIVU and REMU with B != 0 SHALL take IDLE -> BUSY, stay in BUSY for exactly WIDTH cycles (one shift-add or restoring-divide step per cycle), then enter DONE; out_valid rises WIDTH+1 cycles after the accept edge.
REQ-019 DONE -> IDLE on out_valid && out_ready; no new request is accepted in the same cycle.
REQ-020 In DONE, ALU_Out and all flags SHALL hold stable while out_ready = 0, for an unbounded number of cycles.
REQ-021 ADD: Carry_Out = bit WIDTH of the (WIDTH+1)-bit unsigned sum; Overflow = 1 when both operands have the same sign and the result sign differs.
REQ-022 SUB: result A - B; Carry_Out = 1 when there is no unsigned borrow (A >= B); Overflow = 1 when operand signs differ and the result sign differs from A.
REQ-023 For all other ops, Carry_Out = 0 and Overflow = 0.
REQ-024 Zero = (ALU_Out == 0) for every op.
REQ-025 Divide by zero SHALL produce: DIVU result all ones; REMU result = A; Div_Zero = 1. Div_Zero = 0 for every other case.
REQ-026 MUL/MULHU SHALL form the full 2*WIDTH-bit unsigned product; the selected half is returned.
REQ-027 When out_valid = 0, ALU_Out and flags are don't-care, but SHALL not be X after reset.

Reset
REQ-028 Asserting rst_n low SHALL, without a clock edge, force state = IDLE, out_valid = 0, in_ready = 1, and ALU_Out and all flags = 0.
REQ-029 Reset during BUSY or DONE SHALL abort the operation; no result from it ever appears after reset is released.
REQ-030 The first accept SHALL be possible on the first rising edge after rst_n goes high.

Structure
REQ-031 Package alu_pkg SHALL hold the 4-bit opcode constants, the state enum (IDLE/BUSY/DONE) and the is_multicycle(op) function.
REQ-032 Sub-module seq_alu_muldiv SHALL hold the iterative multiply/divide datapath:
- start, op and operand inputs
- step counter of width $clog2(WIDTH+1)
- done pulse and 2*WIDTH-bit accumulator
REQ-033 seq_alu SHALL own the handshake FSM, the single-cycle ops and the output registers.

Verification (WIDTH=32)
REQ-034 ADD 0x7FFFFFFF + 0x00000001 -> ALU_Out 0x80000000, Overflow = 1, Carry_Out = 0, out_valid 1 cycle after accept.
REQ-035 SUB 5 - 5 -> 0, Zero = 1, Carry_Out = 1; SUB 0 - 1 -> 0xFFFFFFFF, Carry_Out = 0, Overflow = 0.
REQ-036 MUL 0xFFFFFFFF * 2 -> 0xFFFFFFFE and MULHU on the same operands -> 0x00000001; out_valid exactly 33 cycles after accept; in_ready = 0 throughout.
REQ-037 DIVU 100 / 7 -> 14 and REMU -> 2, latency 33 cycles; DIVU 0x1234 / 0 -> 0xFFFFFFFF with Div_Zero = 1, latency 1 cycle.
REQ-038 Hold out_ready = 0 for 5 cycles in DONE -> outputs stable and in_ready = 0; raise out_ready -> IDLE on the next edge.
REQ-039 Pull rst_n low at BUSY cycle 10 of a MUL -> out_valid = 0 and in_ready = 1 immediately; the next ADD 3 + 4 returns 7.
